// File: rtl/stream_demux_pkg.sv
// Shared types and limits for the stream_demux_n 1-to-N stream demultiplexer.
package stream_demux_pkg;

   localparam int unsigned MAX_CH = 16;

   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE = 1'b0;
   localparam state_t ST_PKT  = 1'b1;

endpackage

// File: rtl/stream_demux_n_if.sv
// Upstream beat + per-channel downstream bundle for stream_demux_n.
interface stream_demux_n_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NUM_CH = 4
);
   localparam int unsigned SEL_W = $clog2(NUM_CH);

   logic [DATA_W-1:0]        in_data;
   logic [SEL_W-1:0]         in_sel;
   logic                     in_last;
   logic                     in_valid;
   logic                     in_ready;
   logic [NUM_CH*DATA_W-1:0] out_data;
   logic [NUM_CH-1:0]        out_last;
   logic [NUM_CH-1:0]        out_valid;
   logic [NUM_CH-1:0]        out_ready;
   logic                     err_sel;

   // Producer/consumer side of the demux
   modport master (
      output in_data, in_sel, in_last, in_valid, out_ready,
      input  in_ready, out_data, out_last, out_valid, err_sel
   );

   // Demux side
   modport slave (
      input  in_data, in_sel, in_last, in_valid, out_ready,
      output in_ready, out_data, out_last, out_valid, err_sel
   );
endinterface

// File: rtl/demux_out_slot.sv
// One-entry output holding register with valid/ready load and drain.
module demux_out_slot #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   input  logic              out_ready,
   output logic              free_c,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              out_valid
);

   logic [DATA_W-1:0] data_q, data_d;
   logic              last_q, last_d;
   logic              valid_q, valid_d;

   assign free_c    = !valid_q | out_ready;
   assign out_data  = data_q;
   assign out_last  = last_q;
   assign out_valid = valid_q;

   // Load wins over drain so a same-cycle drain+load keeps the slot full
   always_comb begin
      data_d  = data_q;
      last_d  = last_q;
      valid_d = valid_q;
      if (load) begin
         data_d  = load_data;
         last_d  = load_last;
         valid_d = 1'b1;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         last_q  <= last_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/stream_demux_n.sv
// Registered 1-to-NUM_CH stream demux with per-channel holding slots.
// Optional packet select lock enabled by defining STREAM_DEMUX_PKT_LOCK_EN.
module stream_demux_n
   import stream_demux_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NUM_CH = 4
) (
   input logic            clk,
   input logic            rst,
   stream_demux_n_if.slave bus
);

   localparam int unsigned SEL_W = $clog2(NUM_CH);

   if (NUM_CH < 2 || NUM_CH > MAX_CH) begin : g_bad_num_ch
      $error("stream_demux_n: NUM_CH out of range");
   end

   logic [SEL_W-1:0]  eff_sel_c;
   logic              sel_ok_c;
   logic              ready_c;
   logic              accept_c;
   logic [NUM_CH-1:0] free_c;
   logic [NUM_CH-1:0] load_c;
   logic              err_sel_q, err_sel_d;

`ifdef STREAM_DEMUX_PKT_LOCK_EN
   state_t           state_q, state_d;
   logic [SEL_W-1:0] lock_sel_q, lock_sel_d;

   // First accepted beat of a multi-beat packet pins the destination
   always_comb begin
      state_d    = state_q;
      lock_sel_d = lock_sel_q;
      if (state_q == ST_IDLE) begin
         if (accept_c && sel_ok_c && !bus.in_last) begin
            state_d    = ST_PKT;
            lock_sel_d = bus.in_sel;
         end
      end else begin
         if (accept_c && bus.in_last) begin
            state_d = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         lock_sel_q <= '0;
      end else begin
         state_q    <= state_d;
         lock_sel_q <= lock_sel_d;
      end
   end

   assign eff_sel_c = (state_q == ST_PKT) ? lock_sel_q : bus.in_sel;
`else
   assign eff_sel_c = bus.in_sel;
`endif

   assign sel_ok_c = (32'(eff_sel_c) < NUM_CH);

   // Out-of-range selects are always accepted so they can be dropped
   always_comb begin
      ready_c = 1'b1;
      if (sel_ok_c) begin
         ready_c = 1'b0;
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (eff_sel_c == SEL_W'(k)) ready_c = free_c[k];
         end
      end
   end

   assign bus.in_ready = ready_c;
   assign accept_c     = bus.in_valid & ready_c;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
      assign load_c[k] = accept_c & sel_ok_c & (eff_sel_c == SEL_W'(k));

      demux_out_slot #(.DATA_W(DATA_W)) u_slot (
         .clk       (clk),
         .rst       (rst),
         .load      (load_c[k]),
         .load_data (bus.in_data),
         .load_last (bus.in_last),
         .out_ready (bus.out_ready[k]),
         .free_c    (free_c[k]),
         .out_data  (bus.out_data[k*DATA_W +: DATA_W]),
         .out_last  (bus.out_last[k]),
         .out_valid (bus.out_valid[k])
      );
   end

   always_comb begin
      err_sel_d = accept_c & !sel_ok_c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_sel_q <= 1'b0;
      else     err_sel_q <= err_sel_d;
   end

   assign bus.err_sel = err_sel_q;

endmodule

// File: doc/stream_demux_n.md
# stream_demux_n

Registered, parametrised 1-to-N stream demultiplexer with per-channel valid/ready handshake and packet-aware routing. Each accepted input beat is delivered to exactly one of NUM_CH output channels through a one-entry holding slot, so a stalled channel back-pressures only the input and never corrupts other channels. It sits between a single upstream producer and NUM_CH independent consumers in the datapath. It replaces the fixed 1-to-4 combinational demux.

## Interface
- DATA_W, 8, beat payload width in bits
- NUM_CH, 4, number of output channels (2..16, need not be a power of two)
- SEL_W, $clog2(NUM_CH), channel-select width (derived, not overridden)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  DATA_W  input payload
- in_sel  in  SEL_W  destination channel index
- in_last  in  1  final beat of packet
- in_valid  in  1  input beat present
- in_ready  out  1  input beat accepted when in_valid & in_ready
- out_data  out  NUM_CH*DATA_W  channel k payload at bits [k*DATA_W +: DATA_W]
- out_last  out  NUM_CH  per-channel last flag
- out_valid  out  NUM_CH  per-channel beat present
- out_ready  in  NUM_CH  per-channel consumer ready
- err_sel  out  1  one-cycle pulse: beat dropped due to in_sel >= NUM_CH

## Operation
- Each channel owns one slot {data, last, valid}. Slot k is "free" when !out_valid[k] | out_ready[k].
- Effective select: in_sel in IDLE; the latched select lock_sel in PKT.
- in_ready = 1 if effective select >= NUM_CH (beat will be dropped), else free of the selected slot. in_ready is combinational from out_ready, in_sel, state.
- Accepted beat with valid select: load slot; out_valid[k] set next cycle.
- Accepted beat with invalid select: discarded; err_sel = 1 next cycle; no slot changes; state unchanged.
- Slot drain: out_valid[k] & out_ready[k] with no load clears out_valid[k]; simultaneous drain and load keeps out_valid[k]=1 with new data.
- Packet FSM (with macro, see Configuration):
  - IDLE: accepted beat with valid in_sel and in_last=0 -> latch lock_sel=in_sel, go PKT. in_last=1 -> stay IDLE (single-beat packet).
  - PKT: in_sel ignored; beats go to lock_sel; accepted beat with in_last=1 -> IDLE.
- Invalid-select beats never enter PKT.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, err_sel=0, state IDLE, lock_sel=0.
- Latency: input accept at edge n -> out_valid[k]=1 from edge n+1.
- Throughput: one beat per cycle to a channel whose consumer holds out_ready=1; back-to-back beats to different channels also one per cycle.
- Stalled channel (out_valid=1, out_ready=0): in_ready=0 only while that channel is selected; data held stable.
- out_valid, once asserted, holds until handshake (AXI-stream rules); out_data stable while out_valid & !out_ready.
- rst mid-packet: all slots emptied (in-flight beats lost), FSM to IDLE asynchronously.

## Configuration
- STREAM_DEMUX_PKT_LOCK_EN defined: packet FSM active as above; in_sel sampled only on first beat of a packet.
- Undefined: no FSM, no lock_sel; every beat routed by its own in_sel; in_last passed through to out_last unchanged.

## Structure
- Package stream_demux_pkg: state typedef (IDLE, PKT), channel-limit constant MAX_CH=16.
- Sub-module demux_out_slot: one-entry holding register with load/drain handshake, instantiated NUM_CH times via generate.
- Top level holds select decode, in_ready mux, FSM, err_sel register.

## Test plan
- Reset then sel=2, data=0xA5, last=1, all out_ready=1 -> out_valid=4'b0100, out_data ch2=0xA5 one cycle later; other channels remain 0.
- Sweep sel 0,1,2,3 back-to-back, out_ready=all 1 -> one beat per cycle on each channel in order, in_ready constantly 1.
- Hold out_ready[1]=0, send two beats to ch1 -> first held in slot, in_ready=0 for second; release out_ready[1] -> second accepted same cycle, no loss.
- With macro: packet of 3 beats, first sel=3, later beats sel=0 -> all 3 beats on ch3, out_last only on third; FSM back to IDLE.
- NUM_CH=3, sel=3 -> in_ready=1, beat dropped, err_sel pulses one cycle, no out_valid.
- Assert rst mid-packet with a stalled slot -> out_valid=0 immediately; after release first beat uses its own in_sel.
